// File: rtl/counter_controller.sv
// counter_controller: command-driven programmable interval timer around an up-counter.
//   clock, reset      : system clock, asynchronous active-high reset
//   cmd_valid/ready   : command handshake; accepted on edges with cmd_valid & cmd_ready
//   cmd_op, cmd_data  : 00 LOAD limit, 01 START (data[0] = periodic), 10 STOP, 11 CLEAR
//   irq_ack           : clears the sticky irq
//   count             : current counter value
//   running, expired  : state is RUN / EXPIRED
//   done, irq         : one-cycle expiry pulse, sticky expiry flag
module counter_controller #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             irq_ack,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             expired,
   output logic             done,
   output logic             irq
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;
   localparam logic [1:0] OP_LOAD = 2'b00, OP_START = 2'b01, OP_STOP = 2'b10, OP_CLEAR = 2'b11;
   state_t           state;
   logic [WIDTH-1:0] limit;
   logic             periodic;
   logic             accept;
   logic             step;
   logic             mode;
   logic             hit;
   logic             do_load;
   logic             do_start;
   logic             do_stop;
   logic             do_clear;
   assign running = state == RUN;
   assign expired = state == EXPIRED;
   // LOAD stalls while counting so the limit never changes under a running count.
   assign cmd_ready = !(state == RUN && cmd_op == OP_LOAD);
   always_comb begin
      accept   = cmd_valid & cmd_ready;
      do_load  = accept && cmd_op == OP_LOAD;
      do_start = accept && cmd_op == OP_START;
      do_stop  = accept && cmd_op == OP_STOP;
      do_clear = accept && cmd_op == OP_CLEAR;
      // START while running only retunes the mode; the step on that edge uses the new mode.
      step     = state == RUN && !do_stop && !do_clear;
      mode     = do_start ? cmd_data[0] : periodic;
      hit      = step && count == limit;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         limit    <= '1;
         periodic <= 1'b0;
         done     <= 1'b0;
         irq      <= 1'b0;
      end else begin
         done <= hit;
         irq  <= do_clear ? 1'b0 : hit ? 1'b1 : irq_ack ? 1'b0 : irq;
         if (do_start)
            periodic <= cmd_data[0];
         if (do_load) begin
            limit <= cmd_data;
            count <= '0;
            state <= IDLE;
         end else if (do_clear) begin
            count <= '0;
            state <= IDLE;
         end else if (do_stop) begin
            if (state == RUN)
               state <= PAUSE;
         end else if (do_start && state != RUN) begin
            state <= RUN;
            if (state == EXPIRED)
               count <= '0;
         end else if (step) begin
            if (!hit)
               count <= count + 1'b1;
            else if (mode)
               count <= '0;
            else
               state <= EXPIRED;
         end
      end
   end
endmodule

// File: tb/tb_counter_controller.sv
// tb_counter_controller: directed self-checking bench for counter_controller.
module tb_counter_controller;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_data = 8'd0;
   logic       irq_ack = 1'b0;
   logic [7:0] count;
   logic       running;
   logic       expired;
   logic       done;
   logic       irq;
   int         n_chk = 0;
   int         n_pass = 0;
   int         n_done;
   localparam logic [1:0] LOAD = 2'b00, START = 2'b01, STOP = 2'b10, CLEAR = 2'b11;
   counter_controller #(.WIDTH(8)) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .irq_ack(irq_ack), .count(count),
      .running(running), .expired(expired), .done(done), .irq(irq)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic cmd(input logic [1:0] op, input logic [7:0] d);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      tick();
      cmd_valid = 1'b0;
   endtask
   initial begin
      #2;
      chk("rst_count", count, 0);
      chk("rst_done", done, 0);
      chk("rst_irq", irq, 0);
      chk("rst_running", running, 0);
      chk("rst_expired", expired, 0);
      chk("rst_ready", cmd_ready, 1);
      #10 reset = 1'b0;
      // one-shot, limit 5
      cmd(LOAD, 8'd5);
      chk("load_count", count, 0);
      cmd(START, 8'd0);
      chk("os_running", running, 1);
      chk("os_count0", count, 0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("os_count", count, k);
         chk("os_nodone", done, 0);
      end
      tick();
      chk("os_done", done, 1);
      chk("os_expired", expired, 1);
      chk("os_hold", count, 5);
      chk("os_irq", irq, 1);
      tick();
      chk("os_done_pulse", done, 0);
      chk("os_hold2", count, 5);
      chk("os_irq_sticky", irq, 1);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk("os_irq_ack", irq, 0);
      // periodic, limit 3
      cmd(LOAD, 8'd3);
      cmd(START, 8'd1);
      chk("per_count0", count, 0);
      n_done = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("per_count", count, k % 4);
         chk("per_done", done, (k % 4) == 0);
         if (done) n_done++;
      end
      chk("per_pulses", n_done, 3);
      chk("per_running", running, 1);
      chk("per_irq", irq, 1);
      cmd(CLEAR, 8'd0);
      chk("clr_irq", irq, 0);
      chk("clr_count", count, 0);
      chk("clr_idle", running, 0);
      // pause / resume / stall, limit 10
      cmd(LOAD, 8'd10);
      cmd(START, 8'd0);
      tick();
      chk("pr_count1", count, 1);
      cmd_valid = 1'b1;
      cmd_op    = LOAD;
      cmd_data  = 8'd7;
      #1 chk("stall_ready", cmd_ready, 0);
      tick();
      chk("stall_count", count, 2);
      cmd_op = STOP;
      #1 chk("stop_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      chk("stop_paused", running, 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("pause_hold", count, 2);
      end
      cmd(START, 8'd0);
      chk("resume_count", count, 2);
      tick();
      chk("resume_step", count, 3);
      cmd_valid = 1'b1;
      cmd_op    = LOAD;
      cmd_data  = 8'd7;
      tick();
      chk("stall2_count", count, 4);
      cmd_op = STOP;
      tick();
      cmd_op = LOAD;
      #1 chk("load_ready_paused", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      chk("late_load_count", count, 0);
      // STOP on the match edge, limit 7
      cmd(START, 8'd0);
      for (int k = 0; k < 7; k++) tick();
      chk("match_count", count, 7);
      cmd(STOP, 8'd0);
      chk("stopmatch_done", done, 0);
      chk("stopmatch_irq", irq, 0);
      chk("stopmatch_pause", running, 0);
      chk("stopmatch_notexp", expired, 0);
      chk("stopmatch_count", count, 7);
      cmd(START, 8'd0);
      tick();
      chk("pause_expire_done", done, 1);
      chk("pause_expire_exp", expired, 1);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk("ack_irq", irq, 0);
      // restart from EXPIRED, irq_ack on expiry edge
      cmd(START, 8'd0);
      chk("restart_count", count, 0);
      chk("restart_running", running, 1);
      for (int k = 0; k < 7; k++) tick();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk("ackset_irq", irq, 1);
      chk("ackset_done", done, 1);
      // limit 0 periodic
      cmd(LOAD, 8'd0);
      cmd(START, 8'd1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("lim0_done", done, 1);
         chk("lim0_count", count, 0);
      end
      cmd(CLEAR, 8'd0);
      chk("lim0_clr_done", done, 0);
      // limit 255 one-shot, no wrap
      cmd(LOAD, 8'd255);
      cmd(START, 8'd0);
      n_done = 0;
      for (int k = 0; k < 255; k++) begin
         tick();
         if (done) n_done++;
      end
      chk("l255_count", count, 255);
      chk("l255_nodone", n_done, 0);
      tick();
      chk("l255_done", done, 1);
      chk("l255_hold", count, 255);
      chk("l255_exp", expired, 1);
      // async reset mid-run
      cmd(START, 8'd0);
      for (int k = 0; k < 100; k++) tick();
      chk("pre_rst_count", count, 100);
      #2 reset = 1'b1;
      #1;
      chk("arst_count", count, 0);
      chk("arst_running", running, 0);
      chk("arst_irq", irq, 0);
      chk("arst_done", done, 0);
      #1 reset = 1'b0;
      tick();
      chk("post_rst_count", count, 0);
      cmd(START, 8'd0);
      chk("post_rst_running", running, 1);
      for (int k = 0; k < 255; k++) tick();
      chk("post_rst_limit_count", count, 255);
      chk("post_rst_nodone", done, 0);
      tick();
      chk("post_rst_done", done, 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/counter_controller.md
# counter_controller

Command-driven controller that sequences an up-counter as a programmable interval timer. It accepts LOAD/START/STOP/CLEAR commands over a valid/ready handshake and runs the counter from 0 to a programmed limit in one-shot or periodic mode. It raises a one-cycle `done` pulse and a sticky `irq` on each expiry. It sits between a host/command source and the counter datapath, replacing free-running counting with controlled sequencing.

## Interface
- `WIDTH`, default 8: counter and limit width in bits.
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept the presented command; handshake completes on an edge with `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  00 LOAD, 01 START, 10 STOP, 11 CLEAR.
- `cmd_data`  in  WIDTH  LOAD: new limit; START: bit 0 = periodic (1) / one-shot (0); otherwise ignored.
- `irq_ack`  in  1  clears `irq`.
- `count`  out  WIDTH  current counter value.
- `running`  out  1  state == RUN.
- `expired`  out  1  state == EXPIRED.
- `done`  out  1  registered one-cycle pulse on expiry.
- `irq`  out  1  sticky expiry flag.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED. Internal registers: `limit` (WIDTH), `periodic` (1).
- Reset values: state IDLE, `count` 0, `limit` all-ones, `periodic` 0, `done` 0, `irq` 0; `cmd_ready` follows its combinational rule.
- `cmd_ready` = 1 except when state == RUN and `cmd_op` == LOAD; then it is 0 and the LOAD stalls until STOP/CLEAR or expiry.
- LOAD (IDLE/PAUSE/EXPIRED): `limit` <= `cmd_data`, `count` <= 0, state -> IDLE.
- START: `periodic` <= `cmd_data[0]`.
  - From IDLE/PAUSE: state -> RUN, `count` unchanged (resume).
  - From EXPIRED: `count` <= 0, state -> RUN.
  - In RUN: mode updates only; the counting step for that edge executes using the new mode.
- STOP: RUN -> PAUSE, `count` held, no counting step that edge, no `done`. In other states it is accepted with no effect.
- CLEAR (any state): `count` <= 0, state -> IDLE, `irq` <= 0, `done` <= 0.
- Counting step, each edge in RUN with no STOP/CLEAR accepted:
  - If `count` == `limit`: `done` <= 1 and `irq` <= 1. If `periodic`, `count` <= 0 and state stays RUN. Otherwise `count` is held and state -> EXPIRED.
  - Else `count` <= `count` + 1. Cannot overflow, since `count` ≤ `limit` ≤ 2^WIDTH−1.
- `done` <= 0 on every edge where no expiry occurs.
- `irq`: set on expiry; cleared by `irq_ack` or CLEAR. If set and clear occur on the same edge, set wins, except CLEAR, which wins over everything.
- Accepted command beats the counting step on the same edge; the exception is START in RUN (see above).
- `limit` = 0: periodic mode expires on every RUN edge (`done` held high continuously); one-shot expires on the first edge.

## Timing
- Command accepted at edge N: its effect is visible after edge N (`running` = 1 after N for START).
- START with `count` = 0, `limit` = L, accepted at edge N:
  - `count` = k after edge N+k, for k ≤ L.
  - Expiry at edge N+L+1: `done` high for the cycle after it, `irq` = 1.
  - Period = L+1 cycles.
- Outputs are all registered except `cmd_ready`, which is a combinational function of state and `cmd_op`.
- Reset asserted mid-run forces reset values asynchronously, without waiting for a clock edge. The first edge after deassertion behaves as from IDLE.

## Test plan
- Reset/one-shot: reset; LOAD 5; START 0 → `count` 0..5 over 5 edges, `done` pulse one cycle at the 6th edge, `expired` = 1, `count` holds 5, `irq` = 1 until `irq_ack`.
- Periodic: LOAD 3; START 1; run 12 edges → `done` pulses every 4 cycles (3 pulses), `count` sequence 1,2,3,0,1,2,3,0…
- Pause/resume and stall: during RUN at `count` 2, STOP → `count` stays 2 for 5 cycles. LOAD presented during RUN shows `cmd_ready` = 0 and is accepted only after STOP. START after STOP resumes at 2.
- Simultaneous events:
  - STOP on the match edge → no `done`, state PAUSE.
  - `irq_ack` on an expiry edge → `irq` remains 1.
  - CLEAR with pending `irq` → `irq` 0, `count` 0.
- Boundaries: LOAD 0; START 1 → `done` high every cycle. LOAD 255 one-shot → expiry after 256 cycles with no wrap. START from EXPIRED restarts from 0.
- Async reset mid-run at `count` 100 → outputs zero immediately between edges. After release, START resumes from IDLE with `limit` 255.
